// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory controller.
// Byte-lane enable generation lives here so the controller and any bus model agree on lane order.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUS   = 2'd1,
      DONE  = 2'd2,
      DRAIN = 2'd3
   } dmem_state_e;

   typedef enum logic [1:0] {
      SIZE_WORD = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_BYTE = 2'd2
   } mem_size_e;

   localparam logic [31:0] SC_SUCCESS = 32'd1;

   // Byte select wins if both size bits are set.
   function automatic mem_size_e size_of(input logic half, input logic is_byte);
      if (is_byte)
         size_of = SIZE_BYTE;
      else if (half)
         size_of = SIZE_HALF;
      else
         size_of = SIZE_WORD;
   endfunction

   function automatic logic [3:0] byte_enable(input logic [1:0] addr_lo,
                                              input logic       half,
                                              input logic       is_byte,
                                              input logic       big_endian);
      logic [1:0] lane;
      lane = big_endian ? ~addr_lo : addr_lo;
      if (is_byte)
         byte_enable = 4'b0001 << lane;
      else if (half)
         byte_enable = (addr_lo[1] ^ big_endian) ? 4'b1100 : 4'b0011;
      else
         byte_enable = 4'hF;
   endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Single-outstanding request/acknowledge data bus between the MEM-stage controller and memory.
interface dmem_ctrl_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/load_align.sv
// Combinational load formatter: picks the addressed byte/half out of the bus word,
// right-justifies it and sign- or zero-extends it.
module load_align
   import mem_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic [31:0] bus_rdata,
   input  logic [1:0]  addr_lo,
   input  mem_size_e   size,
   input  logic        sign,
   output logic [31:0] data
);

   logic [1:0]  lane;
   logic [7:0]  byte_val;
   logic [15:0] half_val;

   always_comb begin
      lane     = BIG_ENDIAN ? ~addr_lo : addr_lo;
      byte_val = bus_rdata[7:0];
      case (lane)
         2'd0:    byte_val = bus_rdata[7:0];
         2'd1:    byte_val = bus_rdata[15:8];
         2'd2:    byte_val = bus_rdata[23:16];
         default: byte_val = bus_rdata[31:24];
      endcase
      half_val = (addr_lo[1] ^ BIG_ENDIAN) ? bus_rdata[31:16] : bus_rdata[15:0];
      case (size)
         SIZE_BYTE: data = {{24{sign & byte_val[7]}}, byte_val};
         SIZE_HALF: data = {{16{sign & half_val[15]}}, half_val};
         default:   data = bus_rdata;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: one bus transaction at a time, pipeline stall while it
// is in flight, load alignment, LL/SC link tracking and address-error detection.
module dmem_ctrl
   import mem_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        mem_half,
   input  logic        mem_byte,
   input  logic        mem_sign_ext,
   input  logic        llsc,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] mem_read_data,
   output logic        stall_controller,
   output logic        adel,
   output logic        ades,
   dmem_ctrl_if.master bus
);

   dmem_state_e state;
   mem_size_e   size;
   mem_size_e   op_size;
   logic [1:0]  op_addr_lo;
   logic        op_sign;
   logic        op_ll;
   logic        op_sc;
   logic        link_valid;
   logic [29:0] link_addr;
   logic [31:0] rdata_q;
   logic [31:0] hold_q;
   logic [31:0] aligned;
   logic [31:0] done_value;
   logic [31:0] store_rep;
   logic        access;
   logic        misaligned;
   logic        sc_fail;
   logic        accept;
   logic        idle;

   load_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_load_align (
      .bus_rdata (bus.bus_rdata),
      .addr_lo   (op_addr_lo),
      .size      (op_size),
      .sign      (op_sign),
      .data      (aligned)
   );

   // Reset also masks the combinational outputs so they read as reset values while rst is high.
   always_comb begin
      idle       = (state == IDLE);
      size       = size_of(mem_half, mem_byte);
      access     = (mem_read | mem_write) & ~flush & ~rst;
      misaligned = ((size == SIZE_HALF) & addr[0]) |
                   ((size == SIZE_WORD) & (addr[1:0] != 2'b00));
      sc_fail    = idle & access & mem_write & llsc & ~misaligned &
                   ~(link_valid & (addr[31:2] == link_addr));
      accept     = idle & access & ~misaligned & ~sc_fail;
      adel       = idle & access & misaligned & mem_read;
      ades       = idle & access & misaligned & mem_write;
      stall_controller = accept | (state == BUS);
      done_value = op_sc ? SC_SUCCESS : rdata_q;
      store_rep  = wdata;
      case (size)
         SIZE_BYTE: store_rep = {4{wdata[7:0]}};
         SIZE_HALF: store_rep = {2{wdata[15:0]}};
         default:   store_rep = wdata;
      endcase
      if (sc_fail)
         mem_read_data = '0;
      else if (state == DONE)
         mem_read_data = done_value;
      else
         mem_read_data = hold_q;
   end

   // Bus fields are captured at acceptance so a flushed access can drain with its
   // original address even after the pipeline has moved on.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         bus.bus_req   <= 1'b0;
         bus.bus_we    <= 1'b0;
         bus.bus_addr  <= '0;
         bus.bus_be    <= '0;
         bus.bus_wdata <= '0;
         op_size       <= SIZE_WORD;
         op_addr_lo    <= '0;
         op_sign       <= 1'b0;
         op_ll         <= 1'b0;
         op_sc         <= 1'b0;
         link_valid    <= 1'b0;
         link_addr     <= '0;
         rdata_q       <= '0;
         hold_q        <= '0;
      end else begin
         if (flush)
            link_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state         <= BUS;
                  bus.bus_req   <= 1'b1;
                  bus.bus_we    <= mem_write;
                  bus.bus_addr  <= {addr[31:2], 2'b00};
                  bus.bus_be    <= byte_enable(addr[1:0], mem_half, mem_byte, BIG_ENDIAN);
                  bus.bus_wdata <= store_rep;
                  op_size       <= size;
                  op_addr_lo    <= addr[1:0];
                  op_sign       <= mem_sign_ext;
                  op_ll         <= mem_read & llsc;
                  op_sc         <= mem_write & llsc;
               end else if (sc_fail) begin
                  hold_q <= '0;
               end
            end
            BUS: begin
               if (bus.bus_ack) begin
                  bus.bus_req <= 1'b0;
                  if (flush) begin
                     state <= IDLE;
                  end else begin
                     state   <= DONE;
                     rdata_q <= aligned;
                     if (op_ll) begin
                        link_valid <= 1'b1;
                        link_addr  <= bus.bus_addr[31:2];
                     end
                     if (op_sc)
                        link_valid <= 1'b0;
                  end
               end else if (flush) begin
                  state <= DRAIN;
               end
            end
            DONE: begin
               hold_q <= done_value;
               state  <= IDLE;
            end
            DRAIN: begin
               if (bus.bus_ack) begin
                  bus.bus_req <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: loads, stores, misalignment, LL/SC, flush drain and mid-bus reset.
module tb_dmem_ctrl;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        mem_read;
   logic        mem_write;
   logic        mem_half;
   logic        mem_byte;
   logic        mem_sign_ext;
   logic        llsc;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] mem_read_data;
   logic        stall_controller;
   logic        adel;
   logic        ades;
   int          checks;
   int          errors;
   int          stallCycles;

   dmem_ctrl_if bus_if ();

   dmem_ctrl #(.BIG_ENDIAN(1'b0)) dut (
      .clk              (clk),
      .rst              (rst),
      .flush            (flush),
      .mem_read         (mem_read),
      .mem_write        (mem_write),
      .mem_half         (mem_half),
      .mem_byte         (mem_byte),
      .mem_sign_ext     (mem_sign_ext),
      .llsc             (llsc),
      .addr             (addr),
      .wdata            (wdata),
      .mem_read_data    (mem_read_data),
      .stall_controller (stall_controller),
      .adel             (adel),
      .ades             (ades),
      .bus              (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic nextCycle;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input logic half,
                                input logic byt, input logic sgn, input logic ll,
                                input logic [31:0] a, input logic [31:0] d);
      mem_read     = rd;
      mem_write    = wr;
      mem_half     = half;
      mem_byte     = byt;
      mem_sign_ext = sgn;
      llsc         = ll;
      addr         = a;
      wdata        = d;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      flush  = 1'b0;
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = '0;
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      nextCycle();
      nextCycle();
      checkOutput("rst_mem_read_data", mem_read_data, 32'h0);
      checkOutput("rst_stall", {31'b0, stall_controller}, 32'h0);
      checkOutput("rst_adel_ades", {30'b0, adel, ades}, 32'h0);
      checkOutput("rst_bus_req_we", {30'b0, bus_if.bus_req, bus_if.bus_we}, 32'h0);
      checkOutput("rst_bus_be", {28'b0, bus_if.bus_be}, 32'h0);
      checkOutput("rst_bus_addr", bus_if.bus_addr, 32'h0);
      checkOutput("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
      rst = 1'b0;

      $display("[TB] LB signed at 0x1003");
      nextCycle();
      stallCycles = 0;
      applyStimulus(1, 0, 0, 1, 1, 0, 32'h1003, 32'h0);
      #1;
      stallCycles += int'(stall_controller);
      checkOutput("lb_idle_no_req", {31'b0, bus_if.bus_req}, 32'h0);
      nextCycle();
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = 32'h80FF_FF7F;
      #1;
      stallCycles += int'(stall_controller);
      checkOutput("lb_bus_req", {31'b0, bus_if.bus_req}, 32'h1);
      checkOutput("lb_bus_addr", bus_if.bus_addr, 32'h0000_1000);
      checkOutput("lb_bus_be", {28'b0, bus_if.bus_be}, 32'h8);
      nextCycle();
      bus_if.bus_ack = 1'b0;
      #1;
      stallCycles += int'(stall_controller);
      checkOutput("lb_done_data", mem_read_data, 32'hFFFF_FF80);
      checkOutput("lb_done_req_low", {31'b0, bus_if.bus_req}, 32'h0);
      checkOutput("lb_stall_cycles", stallCycles, 32'd2);
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      nextCycle();
      checkOutput("lb_data_held", mem_read_data, 32'hFFFF_FF80);

      $display("[TB] SH at 0x2002 with delayed ack");
      stallCycles = 0;
      applyStimulus(0, 1, 1, 0, 0, 0, 32'h2002, 32'h0000_ABCD);
      #1;
      stallCycles += int'(stall_controller);
      nextCycle();
      #1;
      stallCycles += int'(stall_controller);
      checkOutput("sh_bus_be", {28'b0, bus_if.bus_be}, 32'hC);
      checkOutput("sh_bus_wdata", bus_if.bus_wdata, 32'hABCD_ABCD);
      checkOutput("sh_bus_addr", bus_if.bus_addr, 32'h0000_2000);
      checkOutput("sh_bus_we", {31'b0, bus_if.bus_we}, 32'h1);
      for (int i = 0; i < 2; i++) begin
         nextCycle();
         #1;
         stallCycles += int'(stall_controller);
         checkOutput("sh_wait_req", {31'b0, bus_if.bus_req}, 32'h1);
      end
      nextCycle();
      bus_if.bus_ack = 1'b1;
      #1;
      stallCycles += int'(stall_controller);
      nextCycle();
      bus_if.bus_ack = 1'b0;
      #1;
      stallCycles += int'(stall_controller);
      checkOutput("sh_stall_cycles", stallCycles, 32'd5);
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

      $display("[TB] misaligned LW at 0x3001");
      nextCycle();
      applyStimulus(1, 0, 0, 0, 0, 0, 32'h3001, 32'h0);
      #1;
      checkOutput("lw_mis_adel", {31'b0, adel}, 32'h1);
      checkOutput("lw_mis_ades", {31'b0, ades}, 32'h0);
      checkOutput("lw_mis_stall", {31'b0, stall_controller}, 32'h0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      #1;
      checkOutput("lw_mis_no_req", {31'b0, bus_if.bus_req}, 32'h0);
      checkOutput("lw_mis_adel_gone", {31'b0, adel}, 32'h0);

      $display("[TB] LL then SC to 0x4000");
      nextCycle();
      applyStimulus(1, 0, 0, 0, 0, 1, 32'h4000, 32'h0);
      nextCycle();
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = 32'h1234_5678;
      nextCycle();
      bus_if.bus_ack = 1'b0;
      #1;
      checkOutput("ll_data", mem_read_data, 32'h1234_5678);
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      nextCycle();
      applyStimulus(0, 1, 0, 0, 0, 1, 32'h4000, 32'hDEAD_BEEF);
      #1;
      checkOutput("sc1_stall", {31'b0, stall_controller}, 32'h1);
      nextCycle();
      bus_if.bus_ack = 1'b1;
      #1;
      checkOutput("sc1_bus_req", {31'b0, bus_if.bus_req}, 32'h1);
      checkOutput("sc1_bus_we", {31'b0, bus_if.bus_we}, 32'h1);
      checkOutput("sc1_bus_wdata", bus_if.bus_wdata, 32'hDEAD_BEEF);
      nextCycle();
      bus_if.bus_ack = 1'b0;
      #1;
      checkOutput("sc1_status", mem_read_data, 32'h1);
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      nextCycle();
      applyStimulus(0, 1, 0, 0, 0, 1, 32'h4000, 32'hDEAD_BEEF);
      #1;
      checkOutput("sc2_status", mem_read_data, 32'h0);
      checkOutput("sc2_stall", {31'b0, stall_controller}, 32'h0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      #1;
      checkOutput("sc2_no_req", {31'b0, bus_if.bus_req}, 32'h0);

      $display("[TB] LL, flush, SC");
      nextCycle();
      applyStimulus(1, 0, 0, 0, 0, 1, 32'h4000, 32'h0);
      nextCycle();
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = 32'hCAFE_F00D;
      nextCycle();
      bus_if.bus_ack = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      nextCycle();
      flush = 1'b1;
      #1;
      checkOutput("llf_data_before", mem_read_data, 32'hCAFE_F00D);
      nextCycle();
      flush = 1'b0;
      applyStimulus(0, 1, 0, 0, 0, 1, 32'h4000, 32'h1111_1111);
      #1;
      checkOutput("llf_sc_status", mem_read_data, 32'h0);
      checkOutput("llf_sc_stall", {31'b0, stall_controller}, 32'h0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

      $display("[TB] flush mid-BUS drains");
      nextCycle();
      applyStimulus(1, 0, 0, 0, 0, 0, 32'h5000, 32'h0);
      nextCycle();
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = 32'h5555_AAAA;
      nextCycle();
      bus_if.bus_ack = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      nextCycle();
      applyStimulus(1, 0, 0, 0, 0, 0, 32'h5004, 32'h0);
      nextCycle();
      flush = 1'b1;
      nextCycle();
      flush = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      #1;
      checkOutput("drain_req_held", {31'b0, bus_if.bus_req}, 32'h1);
      checkOutput("drain_stall", {31'b0, stall_controller}, 32'h0);
      nextCycle();
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = 32'h9999_9999;
      #1;
      checkOutput("drain_req_until_ack", {31'b0, bus_if.bus_req}, 32'h1);
      nextCycle();
      bus_if.bus_ack = 1'b0;
      #1;
      checkOutput("drain_req_dropped", {31'b0, bus_if.bus_req}, 32'h0);
      checkOutput("drain_data_kept", mem_read_data, 32'h5555_AAAA);

      $display("[TB] reset mid-BUS");
      nextCycle();
      applyStimulus(1, 0, 0, 0, 0, 0, 32'h6000, 32'h0);
      nextCycle();
      checkOutput("rstbus_req", {31'b0, bus_if.bus_req}, 32'h1);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("rstbus_req_low", {31'b0, bus_if.bus_req}, 32'h0);
      checkOutput("rstbus_addr", bus_if.bus_addr, 32'h0);
      checkOutput("rstbus_stall", {31'b0, stall_controller}, 32'h0);
      checkOutput("rstbus_data", mem_read_data, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      nextCycle();
      rst = 1'b0;
      nextCycle();
      applyStimulus(1, 0, 1, 0, 0, 0, 32'h6002, 32'h0);
      #1;
      checkOutput("lhu_stall", {31'b0, stall_controller}, 32'h1);
      nextCycle();
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = 32'h8001_1234;
      #1;
      checkOutput("lhu_bus_be", {28'b0, bus_if.bus_be}, 32'hC);
      nextCycle();
      bus_if.bus_ack = 1'b0;
      #1;
      checkOutput("lhu_data", mem_read_data, 32'h0000_8001);
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      nextCycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
